// File: rtl/debounced_input_pio.sv
// -----------------------------------------------------------------------------
// debounced_input_pio
//
// Avalon-MM slave input port for external switches and pushbuttons. Each
// input bit is synchronised into the clk domain, debounced by its own
// stability counter, and edges of the debounced value are latched into a
// write-1-to-clear capture register. A maskable level interrupt is raised
// while any captured, unmasked edge is pending.
//
// Word address map (same layout as the output PIOs on the bridge):
//   0  data          debounced input state (read only)
//   1  reserved      reads 0, writes ignored
//   2  interruptmask per-bit irq enable (read/write)
//   3  edgecapture   captured edges (read, write 1 to clear)
//
// Parameters:
//   WIDTH           number of input bits (1..32)
//   SYNC_STAGES     synchroniser depth per bit (2..4)
//   DEBOUNCE_CYCLES stable cycles needed to accept a change; 0 bypasses
//   EDGE_TYPE       capture on 0 rising, 1 falling, 2 any edge
//   IN_RESET_LEVEL  reset value of synchroniser and debounced state bits
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   address     word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data (only the low WIDTH bits are stored)
//   in_port     asynchronous external inputs
//   readdata    read data, zero-extended, combinational on address
//   irq         level interrupt request
// -----------------------------------------------------------------------------
module debounced_input_pio #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0,
    parameter int IN_RESET_LEVEL  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Counter wide enough to hold DEBOUNCE_CYCLES; kept at one bit when the
    // debounce is bypassed so the declarations stay legal.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    // The counter value on which the next mismatching cycle completes the
    // stability window.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((DEBOUNCE_CYCLES > 0) ? (DEBOUNCE_CYCLES - 1) : 0);

    localparam logic [WIDTH-1:0] RST_VEC = (IN_RESET_LEVEL != 0) ? '1 : '0;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    // -------------------------------------------------------------------------
    // Synchroniser chain
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] sync_in;

    always_comb begin
        sync_d[0] = in_port;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // NOTE: every element of a register array is reset explicitly; these are
    // plain flops, not a RAM, so there is no reason to leave any of them X.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RST_VEC;
            end
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // stage samples the previous stage's old value on the same edge.
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Per-bit debounce
    //
    // A bit's counter runs only while the synchronised input disagrees with
    // the debounced state; any agreement resets it, so a glitch shorter than
    // the window never moves the debounced value.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] db_q;
    logic [WIDTH-1:0] db_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        // NOTE: defaults first, so no path through this block leaves a
        // variable unassigned and infers a latch.
        db_d = db_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
        end

        if (DEBOUNCE_CYCLES == 0) begin
            db_d = sync_in;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_in[i] != db_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        db_d[i] = sync_in[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_q <= RST_VEC;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Edge detection on the debounced value
    //
    // Comparing db_d against db_q flags the edge in the same cycle db_q takes
    // its new value, so the capture bit and db change on the same clk edge.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_sel;

    assign rise = db_d & ~db_q;
    assign fall = ~db_d & db_q;

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_sel = rise;
            1:       edge_sel = fall;
            default: edge_sel = rise | fall;
        endcase
    end

    // -------------------------------------------------------------------------
    // Register writes
    // -------------------------------------------------------------------------
    logic             wr_en;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;

    assign wr_en = chipselect && !write_n;

    always_comb begin
        mask_d   = mask_q;
        edge_clr = '0;
        if (wr_en && (address == ADDR_MASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_EDGE)) begin
            edge_clr = writedata[WIDTH-1:0];
        end
        // A new edge arriving together with a clear keeps the bit set, so an
        // event is never lost to a software acknowledge racing it.
        edgecap_d = (edgecap_q & ~edge_clr) | edge_sel;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q    <= '0;
            edgecap_q <= '0;
        end else begin
            mask_q    <= mask_d;
            edgecap_q <= edgecap_d;
        end
    end

    // Upper write-data bits have no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    // -------------------------------------------------------------------------
    // Read mux and interrupt
    //
    // Zero wait states: readdata follows address directly and does not depend
    // on chipselect. Reads never disturb edgecapture.
    // -------------------------------------------------------------------------
    always_comb begin
        case (address)
            ADDR_DATA: readdata = 32'(db_q);
            ADDR_MASK: readdata = 32'(mask_q);
            ADDR_EDGE: readdata = 32'(edgecap_q);
            default:   readdata = 32'd0;
        endcase
    end

    assign irq = |(edgecap_q & mask_q);

endmodule

// File: doc/debounced_input_pio.md
Name: debounced_input_pio

Overview:
- Avalon-MM slave input port, the read-side counterpart to the system's output PIOs (LEDs).
- Samples external switches/pushbuttons, synchronises and debounces each bit, and latches qualifying edges in a capture register.
- Raises a maskable interrupt toward the HPS/Nios interrupt controller.
- Sits on the lightweight bridge beside the LED PIOs, with the same 2-bit word address map.

Parameters:
- WIDTH, 4: number of input bits (1..32).
- SYNC_STAGES, 2: flip-flop synchroniser depth per bit (2..4).
- DEBOUNCE_CYCLES, 50000: consecutive stable clk cycles required before the debounced state changes; 0 bypasses debounce.
- EDGE_TYPE, 0: edge that sets a capture bit; 0 rising, 1 falling, 2 any.
- IN_RESET_LEVEL, 0: reset value of every synchroniser and debounced-state bit.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  word address: 0 data, 1 reserved, 2 interruptmask, 3 edgecapture.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  read data, zero-extended.
- irq  out  1  level interrupt request.

Behaviour:
- Reset: sync chain and debounced state = IN_RESET_LEVEL replicated; counters, interruptmask and edgecapture = 0; irq = 0. Reset is asynchronous on assert and released on a clk edge.
- Synchroniser: in_port passes through SYNC_STAGES registers to give s[i].
- Debounce, per bit, independent counter of width clog2(DEBOUNCE_CYCLES+1):
  - if s[i] == db[i]: counter is cleared.
  - else counter increments; when it would reach DEBOUNCE_CYCLES, db[i] <= s[i] and counter clears in the same cycle.
  - Any glitch shorter than DEBOUNCE_CYCLES leaves db unchanged.
  - DEBOUNCE_CYCLES=0: db[i] <= s[i] every cycle.
- Latency, DEBOUNCE_CYCLES=N>0: db follows a stable in_port change exactly SYNC_STAGES+N clk edges after the change is sampled.
- Edge detect:
  - rise[i] = db_next & ~db, fall[i] = ~db_next & db, evaluated on the cycle db updates.
  - sel = rise, fall, or rise|fall per EDGE_TYPE.
- edgecapture:
  - edgecapture[i] <= 1 on sel[i].
  - A write to address 3 clears each bit where writedata[i]=1.
  - Set and clear in the same cycle: set wins, so the bit stays 1.
  - Bits >= WIDTH read 0.
- interruptmask: written from writedata[WIDTH-1:0] when chipselect & ~write_n & address==2.
- Writes to address 0 or 1 are ignored.
- irq = |(edgecapture & interruptmask), combinational from registers; one cycle after the capturing edge; stays high until cleared or masked.
- Reads: zero wait states, readdata combinational on address:
  - 0: db
  - 1: 0
  - 2: interruptmask
  - 3: edgecapture
  - zero-extended to 32 bits; chipselect not required for the read mux.
- Reading does not clear edgecapture (write-1-to-clear only).
- Reset mid-debounce: the counter is discarded; no edge is captured on reset release.

Test Plan:
- Reset value, WIDTH=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2, in_port=0 held: read addr 0/2/3 -> 0x0 each; irq=0.
- Stable change: in_port 0->0x1 held -> db[0] rises exactly 6 clk edges later; read addr 0 = 0x1; with EDGE_TYPE=0, addr 3 = 0x1.
- Glitch reject: in_port[1] high 3 cycles then low -> db and edgecapture remain 0x0; a 4+ cycle pulse sets edgecapture[1].
- Interrupt: mask write 0x2, edge on bit1 -> irq=1 next cycle; write addr 3 data 0x2 -> irq=0 next cycle; edge on bit0 with mask 0x2 -> edgecapture=0x1, irq=0.
- Collision: a write-1-to-clear to bit1 in the same cycle a new bit1 edge is captured -> edgecapture[1]=1 afterwards, irq stays 1.
- Edge types and reset: EDGE_TYPE=1, in_port 0xF->0x0 captures 0xF; EDGE_TYPE=2 pulse captures on rise. Assert reset mid-count -> all registers 0 immediately; no capture after release with in_port=0.
